// File: rtl/common.sv
// rtl/common.sv - shared address, cache line and request-source types
package common;

  localparam int PPTR_W = 32;
  localparam int LINE_W = 128;

  typedef logic [PPTR_W-1:0] pptr_t;
  typedef logic [LINE_W-1:0] cacheline_t;

  // Source of an outstanding read, stored in the tag FIFO
  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  // Round-robin slots, visited in the order I -> DR -> DW
  typedef enum logic [1:0] {
    RR_I  = 2'd0,
    RR_DR = 2'd1,
    RR_DW = 2'd2
  } rr_t;

  // Address sits in the low bits so the hazard compare can slice it directly
  typedef struct packed {
    cacheline_t line;
    pptr_t      addr;
  } wreq_t;

  // Slot that gets first priority after source g has been granted
  function automatic rr_t rr_next(input rr_t g);
    case (g)
      RR_I:    return RR_DR;
      RR_DR:   return RR_DW;
      default: return RR_I;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular FIFO exporting its storage and per-slot valid bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [WIDTH-1:0]              head,
  output logic [DEPTH-1:0][WIDTH-1:0]   entries,
  output logic [DEPTH-1:0]              valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               rd_ptr;
  logic [AW-1:0]               wr_ptr;
  logic [CW-1:0]               count;
  logic                        do_push;
  logic                        do_pop;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Pointer, occupancy and storage update; the push valid-set wins over the pop clear on a shared slot
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr         <= rd_ptr + AW'(1);
        valid[rd_ptr]  <= 1'b0;
      end
      if (do_push) begin
        mem[wr_ptr]    <= push_data;
        wr_ptr         <= wr_ptr + AW'(1);
        valid[wr_ptr]  <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin sharing of the memory port between i-cache and d-cache
module mem_req_arbiter
  import common::*;
#(
  parameter int Q_DEPTH = 4,
  parameter int MAX_OUT = 8
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       icache_req_ren,
  input  pptr_t      icache_req_raddr,
  output logic       icache_req_ready,
  output logic       icache_rec_en,
  output pptr_t      icache_rec_addr,
  output cacheline_t icache_rec_cacheline,

  input  logic       dcache_req_ren,
  input  pptr_t      dcache_req_raddr,
  input  logic       dcache_req_wen,
  input  pptr_t      dcache_req_waddr,
  input  cacheline_t dcache_req_wcacheline,
  output logic       dcache_req_rready,
  output logic       dcache_req_wready,
  output logic       dcache_rec_en,
  output pptr_t      dcache_rec_addr,
  output cacheline_t dcache_rec_cacheline,

  output logic       mem_req_ren,
  output pptr_t      mem_req_raddr,
  output logic       mem_req_wen,
  output pptr_t      mem_req_waddr,
  output cacheline_t mem_req_wcacheline,
  input  logic       mem_req_ready,

  input  logic       mem_rec_en,
  input  pptr_t      mem_rec_addr,
  input  cacheline_t mem_rec_cacheline,

  output logic       err_unexpected
);

  localparam int WQ_W = $bits(wreq_t);

  // Queue interconnect
  logic                             iq_push, iq_pop, iq_full, iq_empty;
  pptr_t                            iq_head;
  logic [Q_DEPTH-1:0][PPTR_W-1:0]   iq_entries;
  logic [Q_DEPTH-1:0]               iq_valid;

  logic                             drq_push, drq_pop, drq_full, drq_empty;
  pptr_t                            drq_head;
  logic [Q_DEPTH-1:0][PPTR_W-1:0]   drq_entries;
  logic [Q_DEPTH-1:0]               drq_valid;

  logic                             dwq_push, dwq_pop, dwq_full, dwq_empty;
  wreq_t                            dwq_in;
  wreq_t                            dwq_head;
  logic [Q_DEPTH-1:0][WQ_W-1:0]     dwq_entries;
  logic [Q_DEPTH-1:0]               dwq_valid;

  logic                             tq_push, tq_pop, tq_full, tq_empty;
  logic [0:0]                       tq_in;
  logic [0:0]                       tq_head;
  logic [MAX_OUT-1:0][0:0]          tq_entries;
  logic [MAX_OUT-1:0]               tq_valid;
  src_t                             tq_src;

  // Arbitration state
  rr_t  rr_ptr;
  rr_t  grant;
  logic grant_valid;
  logic i_elig, dr_elig, dw_elig;
  logic raw_hit;
  logic slot_free;
  logic issue;

  // Readys depend only on registered occupancy and are held low while in reset
  assign icache_req_ready  = !rst && !iq_full;
  assign dcache_req_rready = !rst && !drq_full;
  assign dcache_req_wready = !rst && !dwq_full;

  assign iq_push  = icache_req_ren && icache_req_ready;
  assign drq_push = dcache_req_ren && dcache_req_rready;
  assign dwq_push = dcache_req_wen && dcache_req_wready;
  assign dwq_in   = '{line: dcache_req_wcacheline, addr: dcache_req_waddr};

  sync_fifo #(.WIDTH(PPTR_W), .DEPTH(Q_DEPTH)) u_iq (
    .clk(clk), .rst(rst), .push(iq_push), .push_data(icache_req_raddr), .pop(iq_pop),
    .full(iq_full), .empty(iq_empty), .head(iq_head), .entries(iq_entries), .valid(iq_valid)
  );

  sync_fifo #(.WIDTH(PPTR_W), .DEPTH(Q_DEPTH)) u_drq (
    .clk(clk), .rst(rst), .push(drq_push), .push_data(dcache_req_raddr), .pop(drq_pop),
    .full(drq_full), .empty(drq_empty), .head(drq_head), .entries(drq_entries), .valid(drq_valid)
  );

  sync_fifo #(.WIDTH(WQ_W), .DEPTH(Q_DEPTH)) u_dwq (
    .clk(clk), .rst(rst), .push(dwq_push), .push_data(dwq_in), .pop(dwq_pop),
    .full(dwq_full), .empty(dwq_empty), .head(dwq_head), .entries(dwq_entries), .valid(dwq_valid)
  );

  sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUT)) u_tq (
    .clk(clk), .rst(rst), .push(tq_push), .push_data(tq_in), .pop(tq_pop),
    .full(tq_full), .empty(tq_empty), .head(tq_head), .entries(tq_entries), .valid(tq_valid)
  );

  // Only the d-cache write queue's storage is inspected; the other taps are intentionally idle
  logic unused_fifo_taps;
  assign unused_fifo_taps = ^{iq_entries, iq_valid, drq_entries, drq_valid, tq_entries, tq_valid};

  // Read-after-write hazard: the DRQ head waits while any queued write targets the same line
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (dwq_valid[i] && (dwq_entries[i][PPTR_W-1:0] == drq_head)) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign i_elig  = !iq_empty && !tq_full;
  assign dr_elig = !drq_empty && !tq_full && !raw_hit;
  assign dw_elig = !dwq_empty;

  // Round-robin pick starting at rr_ptr and wrapping I -> DR -> DW
  always_comb begin
    grant       = RR_I;
    grant_valid = i_elig || dr_elig || dw_elig;
    case (rr_ptr)
      RR_I: begin
        if (i_elig)       grant = RR_I;
        else if (dr_elig) grant = RR_DR;
        else              grant = RR_DW;
      end
      RR_DR: begin
        if (dr_elig)      grant = RR_DR;
        else if (dw_elig) grant = RR_DW;
        else              grant = RR_I;
      end
      default: begin
        if (dw_elig)      grant = RR_DW;
        else if (i_elig)  grant = RR_I;
        else              grant = RR_DR;
      end
    endcase
  end

  // The command slot can be refilled when empty or when memory takes it this cycle
  assign slot_free = !(mem_req_ren || mem_req_wen) || mem_req_ready;
  assign issue     = slot_free && grant_valid;

  assign iq_pop  = issue && (grant == RR_I);
  assign drq_pop = issue && (grant == RR_DR);
  assign dwq_pop = issue && (grant == RR_DW);

  // Every issued read records its source so the in-order response can be routed back
  assign tq_push = issue && (grant != RR_DW);
  assign tq_in   = (grant == RR_I) ? 1'(SRC_I) : 1'(SRC_D);
  assign tq_pop  = mem_rec_en && !tq_empty;
  assign tq_src  = src_t'(tq_head);

  // Command slot and round-robin pointer; contents stay put until memory accepts them
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_ren        <= 1'b0;
      mem_req_raddr      <= '0;
      mem_req_wen        <= 1'b0;
      mem_req_waddr      <= '0;
      mem_req_wcacheline <= '0;
      rr_ptr             <= RR_I;
    end else if (slot_free) begin
      mem_req_ren <= 1'b0;
      mem_req_wen <= 1'b0;
      if (issue) begin
        rr_ptr <= rr_next(grant);
        case (grant)
          RR_I: begin
            mem_req_ren   <= 1'b1;
            mem_req_raddr <= iq_head;
          end
          RR_DR: begin
            mem_req_ren   <= 1'b1;
            mem_req_raddr <= drq_head;
          end
          default: begin
            mem_req_wen        <= 1'b1;
            mem_req_waddr      <= dwq_head.addr;
            mem_req_wcacheline <= dwq_head.line;
          end
        endcase
      end
    end
  end

  // Response routing to the cache that issued the read, plus the sticky orphan-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      icache_rec_en        <= 1'b0;
      icache_rec_addr      <= '0;
      icache_rec_cacheline <= '0;
      dcache_rec_en        <= 1'b0;
      dcache_rec_addr      <= '0;
      dcache_rec_cacheline <= '0;
      err_unexpected       <= 1'b0;
    end else begin
      icache_rec_en <= tq_pop && (tq_src == SRC_I);
      dcache_rec_en <= tq_pop && (tq_src == SRC_D);
      if (tq_pop && (tq_src == SRC_I)) begin
        icache_rec_addr      <= mem_rec_addr;
        icache_rec_cacheline <= mem_rec_cacheline;
      end
      if (tq_pop && (tq_src == SRC_D)) begin
        dcache_rec_addr      <= mem_rec_addr;
        dcache_rec_cacheline <= mem_rec_cacheline;
      end
      if (mem_rec_en && tq_empty) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule
